hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low (0 = reset), sampled on clk rise.
REQ-003 SHALL have ports: RnID, RmID  in  5 each  source registers of instruction in ID.
REQ-004 SHALL have ports: useRmID  in  1  ID instruction reads Rm.
REQ-005 SHALL have ports: RdEXout  in  5  destination of instruction in EX.
REQ-006 SHALL have ports: MemReadEXout  in  1  EX instruction is a load.
REQ-007 SHALL have ports: flagSetEX  in  1  EX instruction sets flags; condBrID  in  1  ID instruction is B.cond.
REQ-008 SHALL have ports: branchTakenEX  in  1  branch resolved taken in EX; memBusy  in  1  data memory not ready.
REQ-009 SHALL have ports: pcWrite, ifidWrite, pipeAdvance  out  1 each  stage enables (1 = advance).
REQ-010 SHALL have ports: ifidFlush, idexBubble  out  1 each  squash IF/ID; inject NOP into ID/EX.
REQ-011 SHALL have ports: ctrlState  out  2  current FSM state; memTimeout  out  1  sticky timeout; stallCount  out  16  stall-cycle count.

Function
REQ-012 SHALL implement states RUN=00, LDSTALL=01, FLUSH=10, MEMWAIT=11, registered on clk.
REQ-013 SHALL define loadUse = MemReadEXout & RdEXout!=31 & (RdEXout==RnID | (useRmID & RdEXout==RmID)); X31 never hazards.
REQ-014 SHALL define flagUse = flagSetEX & condBrID.
REQ-015 SHALL drive outputs combinationally in the same cycle, priority memBusy > branchTakenEX > loadUse > flagUse.
REQ-016 SHALL, when memBusy=1 in any state, drive pcWrite=ifidWrite=pipeAdvance=0, ifidFlush=idexBubble=0, next state MEMWAIT.
REQ-017 SHALL, in RUN with branchTakenEX=1, drive pcWrite=1, ifidFlush=1, idexBubble=1, next FLUSH.
REQ-018 SHALL, in RUN with loadUse or flagUse, drive pcWrite=0, ifidWrite=0, idexBubble=1, pipeAdvance=1, next LDSTALL.
REQ-019 SHALL, in RUN with no event, drive pcWrite=ifidWrite=pipeAdvance=1, flush/bubble 0, stay RUN.
REQ-020 SHALL, in LDSTALL and FLUSH, mask loadUse, flagUse and branchTakenEX (EX/ID hold bubbles), drive normal advance, next RUN.
REQ-021 SHALL, in MEMWAIT with memBusy=0, drive normal advance and return to RUN; the frozen EX instruction is re-evaluated in RUN on the following cycle.
REQ-022 SHALL keep an 8-bit wait counter: cleared on entering MEMWAIT, +1 per MEMWAIT cycle with memBusy=1, saturating at 255.
REQ-023 SHALL set memTimeout when the wait counter reaches 255 with memBusy still 1; memTimeout is cleared only by reset.

Reset
REQ-024 SHALL, when reset=0 at a clk edge, load state RUN, wait counter 0, memTimeout 0, stallCount 0.
REQ-025 SHALL, while reset=0, drive pcWrite=ifidWrite=pipeAdvance=0, ifidFlush=idexBubble=0, irrespective of other inputs; reset asserted mid-MEMWAIT or mid-FLUSH aborts to RUN.

Configuration
REQ-026 SHALL, with HAZARD_STALL_CNT_EN defined, increment stallCount by 1 each non-reset cycle with pcWrite=0, saturating at 16'hFFFF.
REQ-027 SHALL, without HAZARD_STALL_CNT_EN, tie stallCount to 16'h0000 with no counter register; all other behaviour identical.

Verification
REQ-028 SHALL cover load-use: MemReadEXout=1, RdEXout=3, RnID=3 -> one cycle pcWrite=0, idexBubble=1, ctrlState=01, then 00 with pcWrite=1.
REQ-029 SHALL cover X31/Rm gating: RdEXout=31=RnID, or RdEXout=5=RmID with useRmID=0 -> no stall, pcWrite=1.
REQ-030 SHALL cover taken branch coincident with loadUse: branchTakenEX=1 -> ifidFlush=1, idexBubble=1, pcWrite=1, next ctrlState=10, no LDSTALL.
REQ-031 SHALL cover memBusy high 3 cycles during RUN -> all enables 0 for 3 cycles, ctrlState=11, return to 00; memTimeout stays 0.
REQ-032 SHALL cover memBusy held 300 cycles -> memTimeout=1 after 255 MEMWAIT cycles, stays 1 after memBusy drops until reset=0.
REQ-033 SHALL cover stallCount with macro defined: 2 load-use stalls plus 3 memBusy cycles -> stallCount=5; without macro -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// -----------------------------------------------------------------------------
// Pipeline hazard controller for a five-stage pipeline.
// It detects these conditions:
//   - load-use hazards between the EX load and the ID sources,
//   - flag-use hazards between an EX flag-setter and an ID B.cond,
//   - taken branches that resolve in EX,
//   - data-memory busy cycles.
// It drives the stage enables, the flush controls and the bubble controls in
// the same cycle.
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-low (0 = reset)
//   RnID, RmID     in   5   source registers of the ID instruction
//   useRmID        in   1   ID instruction reads Rm
//   RdEXout        in   5   destination register of the EX instruction
//   MemReadEXout   in   1   EX instruction is a load
//   flagSetEX      in   1   EX instruction sets flags
//   condBrID       in   1   ID instruction is B.cond
//   branchTakenEX  in   1   branch resolved taken in EX
//   memBusy        in   1   data memory not ready
//   pcWrite        out  1   PC enable
//   ifidWrite      out  1   IF/ID enable
//   pipeAdvance    out  1   enable for the ID/EX stage and later stages
//   ifidFlush      out  1   squash IF/ID
//   idexBubble     out  1   inject NOP into ID/EX
//   ctrlState      out  2   FSM state (RUN=00, LDSTALL=01, FLUSH=10, MEMWAIT=11)
//   memTimeout     out  1   sticky; set after 255 busy MEMWAIT cycles
//   stallCount     out 16   saturating count of cycles with pcWrite=0
//
// Optional feature:
//   HAZARD_STALL_CNT_EN  Define this macro to build the stall-cycle counter.
//                        When it is undefined, stallCount is tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RnID,
  input  logic [4:0]  RmID,
  input  logic        useRmID,
  input  logic [4:0]  RdEXout,
  input  logic        MemReadEXout,
  input  logic        flagSetEX,
  input  logic        condBrID,
  input  logic        branchTakenEX,
  input  logic        memBusy,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        pipeAdvance,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic [1:0]  ctrlState,
  output logic        memTimeout,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10,
    MEMWAIT = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic [7:0] wait_cnt_inc;
  logic       load_use;
  logic       flag_use;

  // X31 is the zero register, so a write to it never creates a dependency.
  assign load_use = MemReadEXout && (RdEXout != 5'd31) &&
                    ((RdEXout == RnID) || (useRmID && (RdEXout == RmID)));
  assign flag_use = flagSetEX && condBrID;

  // The wait counter saturates at 255.
  assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    pcWrite       = 1'b1;
    ifidWrite     = 1'b1;
    pipeAdvance   = 1'b1;
    ifidFlush     = 1'b0;
    idexBubble    = 1'b0;

    if (!reset) begin
      // While reset is held, the pipeline is frozen whatever the other inputs are.
      pcWrite       = 1'b0;
      ifidWrite     = 1'b0;
      pipeAdvance   = 1'b0;
      state_d       = RUN;
      wait_cnt_d    = 8'd0;
      mem_timeout_d = 1'b0;
    end else if (memBusy) begin
      // memBusy has the highest priority. The whole pipeline freezes and no
      // flush or bubble is issued, so the frozen instructions survive.
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      pipeAdvance = 1'b0;
      state_d     = MEMWAIT;
      if (state_q != MEMWAIT) begin
        wait_cnt_d = 8'd0;
      end else begin
        wait_cnt_d = wait_cnt_inc;
        if (wait_cnt_inc == 8'hFF) begin
          mem_timeout_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (branchTakenEX) begin
            // The branch takes priority over a coincident load-use hazard,
            // because the dependent instruction in ID is squashed anyway.
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            state_d    = FLUSH;
          end else if (load_use || flag_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            state_d    = LDSTALL;
          end
        end
        // EX holds a bubble after LDSTALL and FLUSH, so any hazard inputs seen
        // there are stale. Advance normally. After MEMWAIT, the frozen EX
        // instruction is re-evaluated in RUN on the next cycle.
        LDSTALL, FLUSH, MEMWAIT: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign ctrlState  = state_q;
  assign memTimeout = mem_timeout_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pcWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`else
  assign stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  RnID, RmID, RdEXout;
  logic        useRmID, MemReadEXout, flagSetEX, condBrID, branchTakenEX, memBusy;
  logic        pcWrite, ifidWrite, pipeAdvance, ifidFlush, idexBubble;
  logic [1:0]  ctrlState;
  logic        memTimeout;
  logic [15:0] stallCount;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

  // Scoreboard entry: {pcWrite, ifidWrite, pipeAdvance, ifidFlush, idexBubble, ctrlState}
  logic [6:0] exp_q[$];
  string      tag_q[$];

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .RnID(RnID), .RmID(RmID), .useRmID(useRmID),
    .RdEXout(RdEXout), .MemReadEXout(MemReadEXout), .flagSetEX(flagSetEX),
    .condBrID(condBrID), .branchTakenEX(branchTakenEX), .memBusy(memBusy),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .pipeAdvance(pipeAdvance),
    .ifidFlush(ifidFlush), .idexBubble(idexBubble), .ctrlState(ctrlState),
    .memTimeout(memTimeout), .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    RnID = 5'd1; RmID = 5'd2; RdEXout = 5'd10; useRmID = 1'b1;
    MemReadEXout = 1'b0; flagSetEX = 1'b0; condBrID = 1'b0;
    branchTakenEX = 1'b0; memBusy = 1'b0;
  endtask

  // Push the expectation for the inputs just driven. Pop it once the
  // combinational outputs have settled, then advance one clock.
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    logic [6:0] obs;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {pcWrite, ifidWrite, pipeAdvance, ifidFlush, idexBubble, ctrlState};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed pc/ifid/adv/flush/bub/state=%b expected %b", t, obs, e);
    end
    $display("step %-16s pc/ifid/adv/flush/bub/state=%b", t, obs);
    @(posedge clk);
    if (!reset) exp_stalls = 0;
    else if (!e[6]) exp_stalls++;
    #2;
  endtask

  task automatic check_scalar(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h", tag, obs);
  endtask

  task automatic check_stalls(input string tag);
    logic [15:0] exp;
`ifdef HAZARD_STALL_CNT_EN
    exp = 16'(exp_stalls);
`else
    exp = 16'h0000;
`endif
    check_scalar(tag, stallCount, exp);
  endtask

  localparam logic [6:0] NORM_RUN = 7'b11100_00;
  localparam logic [6:0] NORM_LDS = 7'b11100_01;
  localparam logic [6:0] NORM_FL  = 7'b11100_10;
  localparam logic [6:0] NORM_MW  = 7'b11100_11;
  localparam logic [6:0] STALL    = 7'b00101_00;
  localparam logic [6:0] BRFLUSH  = 7'b11111_00;
  localparam logic [6:0] FROZE_R  = 7'b00000_00;
  localparam logic [6:0] FROZE_F  = 7'b00000_10;
  localparam logic [6:0] FROZE_MW = 7'b00000_11;

  initial begin
    idle_inputs();
    reset = 1'b0;
    branchTakenEX = 1'b1;
    memBusy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    // Reset held: outputs are forced low even with events asserted.
    step("reset_hold", FROZE_R);
    check_scalar("reset_timeout", {15'd0, memTimeout}, 16'd0);
    check_stalls("reset_stallcnt");
    reset = 1'b1;
    idle_inputs();
    step("idle_run", NORM_RUN);

    // Load-use on Rn. The hazard inputs stay held into LDSTALL to check masking.
    MemReadEXout = 1'b1; RdEXout = 5'd3; RnID = 5'd3;
    step("loaduse_rn", STALL);
    step("ldstall_masked", NORM_LDS);
    idle_inputs();
    step("after_ldstall", NORM_RUN);

    // X31 never creates a hazard.
    MemReadEXout = 1'b1; RdEXout = 5'd31; RnID = 5'd31;
    step("x31_no_stall", NORM_RUN);

    // An Rm match is ignored when useRmID=0 and stalls when useRmID=1.
    idle_inputs();
    MemReadEXout = 1'b1; RdEXout = 5'd5; RmID = 5'd5; useRmID = 1'b0;
    step("rm_unused", NORM_RUN);
    useRmID = 1'b1;
    step("loaduse_rm", STALL);
    idle_inputs();
    step("ldstall_rm", NORM_LDS);

    // Flag-use hazard.
    flagSetEX = 1'b1; condBrID = 1'b1;
    step("flaguse", STALL);
    idle_inputs();
    step("ldstall_flag", NORM_LDS);
    step("idle_run2", NORM_RUN);

    // A taken branch coincident with a load-use hazard flushes; it does not stall.
    branchTakenEX = 1'b1; MemReadEXout = 1'b1; RdEXout = 5'd3; RnID = 5'd3;
    step("branch_loaduse", BRFLUSH);
    step("flush_masked", NORM_FL);
    idle_inputs();
    step("after_flush", NORM_RUN);

    // memBusy for 3 cycles during RUN.
    memBusy = 1'b1;
    step("membusy_1", FROZE_R);
    step("membusy_2", FROZE_MW);
    step("membusy_3", FROZE_MW);
    memBusy = 1'b0;
    step("memwait_exit", NORM_MW);
    step("after_memwait", NORM_RUN);
    check_scalar("no_timeout", {15'd0, memTimeout}, 16'd0);
    check_stalls("stallcnt_mid");

    // memBusy held for 300 cycles sets the sticky timeout.
    memBusy = 1'b1;
    step("long_busy_0", FROZE_R);
    for (int i = 1; i < 300; i++) begin
      step("long_busy", FROZE_MW);
      if (i == 200) check_scalar("timeout_early", {15'd0, memTimeout}, 16'd0);
    end
    check_scalar("timeout_set", {15'd0, memTimeout}, 16'd1);
    memBusy = 1'b0;
    step("long_exit", NORM_MW);
    step("post_timeout", NORM_RUN);
    check_scalar("timeout_sticky", {15'd0, memTimeout}, 16'd1);
    check_stalls("stallcnt_long");

    // Reset asserted in the middle of FLUSH aborts to RUN and clears the sticky timeout.
    branchTakenEX = 1'b1;
    step("branch_pre_rst", BRFLUSH);
    reset = 1'b0;
    step("rst_in_flush", FROZE_F);
    reset = 1'b1;
    idle_inputs();
    step("rst_flush_run", NORM_RUN);
    check_scalar("timeout_cleared", {15'd0, memTimeout}, 16'd0);

    // Reset asserted in the middle of MEMWAIT.
    memBusy = 1'b1;
    step("busy_pre_rst", FROZE_R);
    reset = 1'b0;
    step("rst_in_memwait", FROZE_MW);
    reset = 1'b1;
    idle_inputs();
    step("rst_mw_run", NORM_RUN);
    check_stalls("stallcnt_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
